// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host that drives the I2C master
// core register port.
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] data;
    } wb_cmd_t;

    localparam logic [2:0] PRER_LO = 3'd0;
    localparam logic [2:0] PRER_HI = 3'd1;
    localparam logic [2:0] CTR     = 3'd2;
    localparam logic [2:0] TXR_RXR = 3'd3;
    localparam logic [2:0] CR_SR   = 3'd4;

    // Writes and timed-out cycles always report zero data.
    function automatic logic [7:0] rsp_read_data(input logic we,
                                                 input logic err,
                                                 input logic [7:0] rdata);
        logic [7:0] res;
        if (we || err) begin
            res = 8'h00;
        end else begin
            res = rdata;
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_host_fifo.sv
// Command FIFO; pointers carry one extra wrap bit so full and empty differ
// only in the MSB.
module wb_host_fifo
    import wb_host_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wb_cmd_t push_data_i,
    input  logic    pop_i,
    output wb_cmd_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        push_ok_s;
    logic        pop_ok_s;
    wb_cmd_t     mem_q [DEPTH];

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic single-cycle initiator: queued register commands in, one
// response (data or timeout error) out per cycle.
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_we_i,
    input  logic [2:0] cmd_addr_i,
    input  logic [7:0] cmd_data_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_we_o,
    output logic       rsp_err_o,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic       wb_ack_i,
    output logic       busy_o
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    wb_state_e     state_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [2:0]    wb_addr_q;
    logic [7:0]    wb_dat_q;
    logic          wb_we_q;
    logic          wb_stb_q;
    logic          wb_cyc_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_we_q;
    logic          rsp_err_q;

    wb_cmd_t       cmd_in_s;
    wb_cmd_t       head_s;
    logic          cmd_push_s;
    logic          cmd_pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;

    assign cmd_in_s   = '{we: cmd_we_i, addr: cmd_addr_i, data: cmd_data_i};
    assign cmd_push_s = cmd_valid_i && !fifo_full_s;
    assign cmd_pop_s  = (state_q == IDLE) && !fifo_empty_s;

    wb_host_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .rst_i       (arst_i),
        .push_i      (cmd_push_s),
        .push_data_i (cmd_in_s),
        .pop_i       (cmd_pop_s),
        .head_o      (head_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // IDLE -> REQ -> RSP -> IDLE guarantees two low-strobe clocks between cycles.
    always_ff @(posedge wb_clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            wb_addr_q   <= 3'd0;
            wb_dat_q    <= 8'h00;
            wb_we_q     <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_cyc_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        wb_addr_q <= head_s.addr;
                        wb_dat_q  <= head_s.data;
                        wb_we_q   <= head_s.we;
                        wb_stb_q  <= 1'b1;
                        wb_cyc_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (wb_ack_i) begin
                        wb_stb_q    <= 1'b0;
                        wb_cyc_q    <= 1'b0;
                        rsp_data_q  <= rsp_read_data(wb_we_q, 1'b0, wb_dat_i);
                        rsp_we_q    <= wb_we_q;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        wb_stb_q    <= 1'b0;
                        wb_cyc_q    <= 1'b0;
                        rsp_data_q  <= rsp_read_data(wb_we_q, 1'b1, wb_dat_i);
                        rsp_we_q    <= wb_we_q;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RSP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    wb_stb_q    <= 1'b0;
                    wb_cyc_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = !fifo_full_s;
    assign busy_o      = (state_q != IDLE) || !fifo_empty_s;
    assign wb_addr_o   = wb_addr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_we_o     = wb_we_q;
    assign wb_stb_o    = wb_stb_q;
    assign wb_cyc_o    = wb_cyc_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_we_o    = rsp_we_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_host_master.sv
// Scoreboard bench for wb_host_master with a per-address Wishbone slave model.
module tb_wb_host_master;

    localparam int TMO = 16;

    logic       clk;
    logic       arst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_we;
    logic       rsp_err;
    logic [2:0] wb_addr;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we;
    logic       wb_stb;
    logic       wb_cyc;
    logic       wb_ack;
    logic       busy;

    wb_host_master #(.CMD_DEPTH(4), .TIMEOUT(TMO)) dut (
        .wb_clk_i    (clk),
        .arst_i      (arst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_data_i  (cmd_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_we_o    (rsp_we),
        .rsp_err_o   (rsp_err),
        .wb_addr_o   (wb_addr),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we),
        .wb_stb_o    (wb_stb),
        .wb_cyc_o    (wb_cyc),
        .wb_ack_i    (wb_ack),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: per-address read data and ack delay in strobe clocks (0 = never acks).
    logic [7:0] rd_tbl [8];
    int         dly_tbl [8];
    int         scnt;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) scnt <= 0;
        else if (wb_stb && !wb_ack) scnt <= scnt + 1;
        else scnt <= 0;
    end

    assign wb_ack   = wb_stb && (dly_tbl[wb_addr] != 0) && (scnt == dly_tbl[wb_addr] - 1);
    assign wb_dat_i = rd_tbl[wb_addr];

    int errors = 0;
    int checks = 0;
    int rsp_hs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [7:0] dat;
        int         len;
    } wbx_t;

    rsp_t rsp_q[$];
    wbx_t wb_q[$];

    // Command monitor: every accepted command predicts its bus cycle and response.
    initial begin
        rsp_t r;
        wbx_t w;
        forever begin
            @(negedge clk);
            if (!arst && cmd_valid && cmd_ready) begin
                r.we   = cmd_we;
                r.err  = (dly_tbl[cmd_addr] == 0);
                r.data = (cmd_we || r.err) ? 8'h00 : rd_tbl[cmd_addr];
                rsp_q.push_back(r);
                w.we   = cmd_we;
                w.addr = cmd_addr;
                w.dat  = cmd_data;
                w.len  = (dly_tbl[cmd_addr] == 0) ? TMO : dly_tbl[cmd_addr];
                wb_q.push_back(w);
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!arst && rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_data", 32'(rsp_data), 32'(rsp_q[0].data));
                    check("rsp_we", 32'(rsp_we), 32'(rsp_q[0].we));
                    check("rsp_err", 32'(rsp_err), 32'(rsp_q[0].err));
                end
                if (rsp_ready) begin
                    rsp_hs++;
                    if (rsp_q.size() != 0) void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Bus monitor: fields, stability, strobe length and inter-cycle gap.
    initial begin
        logic prev;
        int   len;
        int   gap;
        wbx_t cur;
        prev = 1'b0;
        len  = 0;
        gap  = 100;
        cur  = '{we: 1'b0, addr: 3'd0, dat: 8'h00, len: 0};
        forever begin
            @(negedge clk);
            if (arst) begin
                prev = 1'b0;
                len  = 0;
                gap  = 100;
            end else begin
                check("cyc_eq_stb", 32'(wb_cyc), 32'(wb_stb));
                if (wb_stb) begin
                    if (!prev) begin
                        check("stb_gap_ge2", 32'(gap >= 2), 32'd1);
                        if (wb_q.size() == 0) begin
                            check("wb_unexpected", 32'(wb_stb), 32'd0);
                        end else begin
                            cur = wb_q.pop_front();
                            check("wb_addr", 32'(wb_addr), 32'(cur.addr));
                            check("wb_we", 32'(wb_we), 32'(cur.we));
                            check("wb_dat", 32'(wb_dat_o), 32'(cur.dat));
                        end
                        len = 1;
                    end else begin
                        len++;
                        check("wb_hold", 32'({wb_we, wb_addr, wb_dat_o}), 32'({cur.we, cur.addr, cur.dat}));
                    end
                end else begin
                    if (prev) begin
                        check("stb_len", 32'(len), 32'(cur.len));
                        gap = 1;
                    end else begin
                        gap++;
                    end
                end
                prev = wb_stb;
            end
        end
    end

    task automatic send(input logic we, input logic [2:0] a, input logic [7:0] d);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_data  = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_timely", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || rsp_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < 500), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    logic       vwe [6];
    logic [2:0] va  [6];
    logic [7:0] vd  [6];
    int         acc;
    int         hs0;
    int         n;

    initial begin
        rd_tbl  = '{8'h11, 8'h22, 8'h33, 8'h5A, 8'h41, 8'h99, 8'hC3, 8'h77};
        dly_tbl = '{1, 1, 2, 1, 1, 0, 16, 3};
        vwe = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        va  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd3};
        vd  = '{8'h19, 8'h00, 8'h00, 8'h80, 8'h00, 8'h55};
        arst      = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        #2 arst = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(wb_cyc), 32'd0);
        check("rst_stb", 32'(wb_stb), 32'd0);
        check("rst_wb_fields", 32'({wb_we, wb_addr, wb_dat_o}), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_we, rsp_err, rsp_data}), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 arst = 1'b0;

        // Write CTR=0x80, ack after 2 strobe clocks; strobe from second clock after accept.
        send(1'b1, 3'd2, 8'h80);
        @(negedge clk);
        check("lat_stb_low_n1", 32'(wb_stb), 32'd0);
        @(negedge clk);
        check("lat_stb_high_n2", 32'(wb_stb), 32'd1);
        wait_idle();

        // Read CR_SR=0x41, response held for 5 clocks without ready.
        @(posedge clk); #1 rsp_ready = 1'b0;
        send(1'b0, 3'd4, 8'h00);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_seen_read", 32'(rsp_valid), 32'd1);
        repeat (5) @(negedge clk);
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        wait_idle();

        // Timeout write, then a queued read that completes normally.
        send(1'b1, 3'd5, 8'hA5);
        send(1'b0, 3'd3, 8'h00);
        wait_idle();

        // Six back-to-back offers with responses stalled: five accepted.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        acc       = 0;
        cmd_valid = 1'b1;
        cmd_we    = vwe[0];
        cmd_addr  = va[0];
        cmd_data  = vd[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) acc++;
            @(posedge clk); #1;
            if (acc < 6) begin
                cmd_we   = vwe[acc];
                cmd_addr = va[acc];
                cmd_data = vd[acc];
            end
        end
        @(negedge clk);
        check("burst_accepted", 32'(acc), 32'd5);
        check("burst_ready_low", 32'(cmd_ready), 32'd0);
        check("burst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        hs0       = rsp_hs;
        rsp_ready = 1'b1;
        wait_idle();
        check("burst_rsp_count", 32'(rsp_hs - hs0), 32'd5);

        // Ack on the last permitted strobe clock: no error, data captured.
        send(1'b0, 3'd6, 8'h00);
        wait_idle();

        // Reset with a cycle in flight and two commands queued.
        send(1'b1, 3'd5, 8'h01);
        send(1'b1, 3'd5, 8'h02);
        send(1'b1, 3'd5, 8'h03);
        n = 0;
        while (!wb_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_stb", 32'(wb_stb), 32'd1);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        arst = 1'b1;
        #1;
        check("arst_stb", 32'({wb_cyc, wb_stb}), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst_busy", 32'(busy), 32'd0);
        rsp_q.delete();
        wb_q.delete();
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        hs0 = rsp_hs;
        repeat (40) @(negedge clk);
        check("post_rst_no_rsp", 32'(rsp_hs - hs0), 32'd0);
        check("post_rst_stb", 32'(wb_stb), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
